zap_cp15_responder: RTL and testbench
=====================================

Name: zap_cp15_responder

Overview:
- System-control coprocessor (CP15) at the far end of the decode-stage coprocessor handshake.
- Samples the coprocessor request bundle: dav, instruction word, translated physical register index and CPSR snapshot.
- Executes MRC/MCR against an internal CP15 register bank, reading or writing the CPU register file through a dedicated port.
- Answers every request with a single-cycle done pulse, so the decode stage never hangs.

Parameters:
PHY_REGS, 46, physical register count; register index width is $clog2(PHY_REGS).
CP15_ID, 32'h4107_0000, read-only value returned for c0.
CTRL_RESET, 32'h0000_0078, reset value of c1.

Ports:
i_clk  in  1  clock.
i_reset  in  1  asynchronous, active-high reset.
i_copro_dav  in  1  request valid; held high by the issuer until done.
i_copro_word  in  32  full coprocessor instruction.
i_copro_reg  in  $clog2(PHY_REGS)  translated physical CPU register index.
i_copro_mode  in  32  CPSR at issue.
o_copro_done  out  1  one-cycle completion pulse.
o_copro_undef  out  1  one-cycle pulse with done for a rejected request.
o_reg_rd_en  out  1  register-file read strobe.
o_reg_rd_index  out  $clog2(PHY_REGS)  read index.
i_reg_rd_data  in  32  read data, valid one cycle after o_reg_rd_en.
o_reg_wr_en  out  1  register-file write strobe.
o_reg_wr_index  out  $clog2(PHY_REGS)  write index.
o_reg_wr_data  out  32  write data.
i_fault_valid  in  1  MMU fault update.
i_fsr  in  32  fault status.
i_far  in  32  fault address.
o_ctrl  out  32  c1 contents.
o_ttbr  out  32  c2 contents.
o_dac  out  32  c3 contents.
o_cache_inv  out  1  one-cycle pulse on any MCR to c7.
o_tlb_inv  out  1  one-cycle pulse on any MCR to c8.

Behaviour:
- Outputs are registered or decoded from state; no combinational path from i_copro_* to any output.
- Reset values:
  - State IDLE.
  - All strobes and pulses 0; indices and write data 0.
  - c1 = CTRL_RESET; c2, c3, c5, c6 = 0.
- Reset mid-operation aborts to IDLE with no register-file strobe.
- Instruction fields: [20] L (1 = MRC), [19:16] CRn, [11:8] coprocessor number.
- State IDLE, i_copro_dav = 1: latch word, reg and mode; go to DECODE.
- State DECODE: reject, going to DONE with undef = 1, when any of the following holds:
  - coprocessor number != 15;
  - [27:24] != 4'b1110 or [4] != 1 (LDC, STC or CDP);
  - mode[4:0] = 5'b10000 (user mode).
- DECODE, accepted request: MRC goes to WRITE; MCR goes to READ.
- State READ: o_reg_rd_en = 1, o_reg_rd_index = latched reg; go to READ_WAIT.
- State READ_WAIT: commit i_reg_rd_data into CRn; go to DONE. CRn handling:
  - c0 write is ignored.
  - c7 or c8 pulses o_cache_inv or o_tlb_inv in the DONE cycle.
  - c4 and c9..c15 are ignored.
- State WRITE: o_reg_wr_en = 1, o_reg_wr_index = latched reg, o_reg_wr_data = CRn contents; go to DONE.
  - c0 returns CP15_ID; c1, c2, c3, c5, c6 return the register.
  - Any other CRn returns 0.
- State DONE: o_copro_done = 1 (o_copro_undef as decided); go to IDLE unconditionally.
  - A new request cannot be accepted before the cycle after DONE.
  - The issuer has dropped dav by then.
- Latency from the dav-sampled cycle (cycle 0):
  - MRC: write strobe in cycle 2, done in cycle 3.
  - MCR: read strobe in cycle 2, commit and done in cycle 4.
  - Rejected request: done and undef in cycle 2.
- Abort (issuer flushed): dav low while in DECODE or READ returns to IDLE with no done, no commit and no write strobe.
  - From READ_WAIT or WRITE onward the operation commits.
  - Done still pulses and is ignored by the idle issuer.
- Fault update: i_fault_valid loads c5 <= i_fsr and c6 <= i_far in any state.
- Fault vs. MCR commit to c5/c6 in the same cycle: the fault update wins.

Test Plan:
- Reset then MRC p15, c0 to phys reg 3 in SVC mode -> write strobe cycle 2 with index 3, data 32'h4107_0000; done cycle 3, undef 0.
- MCR p15, c2 from reg 5, i_reg_rd_data = 32'h0000_4000 -> read strobe cycle 2 with index 5; o_ttbr = 32'h0000_4000 after cycle 4; done cycle 4.
- MCR p15, c7 -> o_cache_inv high exactly in the done cycle; ctrl, ttbr and dac unchanged.
- MRC p15 in user mode (mode 5'b10000), then MCR to coprocessor 14 -> each gives done and undef in cycle 2 with no register-file strobes.
- MCR to c5 with i_fault_valid = 1 and i_fsr = 32'h5 in the READ_WAIT cycle -> c5 = 32'h5; a following MRC c5 returns 32'h5.
- Dav dropped during READ -> no done, c1 unchanged, next request accepted normally. Separately, async reset asserted mid-WRITE -> wr_en low immediately and c1 = 32'h78.

Source files
------------

// File: rtl/zap_cp15_responder.sv
// CP15 system-control coprocessor: services MRC/MCR from the decode-stage
// coprocessor handshake against a small control register bank.
module zap_cp15_responder #(
  parameter int          PHY_REGS   = 46,
  parameter logic [31:0] CP15_ID    = 32'h4107_0000,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0078
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_copro_dav,
  input  logic [31:0]                 i_copro_word,
  input  logic [$clog2(PHY_REGS)-1:0] i_copro_reg,
  input  logic [31:0]                 i_copro_mode,
  output logic                        o_copro_done,
  output logic                        o_copro_undef,
  output logic                        o_reg_rd_en,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_rd_index,
  input  logic [31:0]                 i_reg_rd_data,
  output logic                        o_reg_wr_en,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_wr_index,
  output logic [31:0]                 o_reg_wr_data,
  input  logic                        i_fault_valid,
  input  logic [31:0]                 i_fsr,
  input  logic [31:0]                 i_far,
  output logic [31:0]                 o_ctrl,
  output logic [31:0]                 o_ttbr,
  output logic [31:0]                 o_dac,
  output logic                        o_cache_inv,
  output logic                        o_tlb_inv
);

  localparam int IDX_W = $clog2(PHY_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_READ, S_READ_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        word_q;
  logic [IDX_W-1:0]   reg_q;
  logic [4:0]         mode_q;
  logic [31:0]        fsr_q;
  logic [31:0]        far_q;
  logic [31:0]        rd_val;
  logic [3:0]         crn;
  logic               unused_ok;

  assign crn = word_q[19:16];

  // Only MRC/MCR to cp15 from a privileged mode is serviced.
  function automatic logic is_rejected(input logic [31:0] w, input logic [4:0] m);
    return (w[11:8] != 4'd15) || (w[27:24] != 4'b1110) || !w[4] || (m == 5'b10000);
  endfunction

  always_comb begin
    rd_val = '0;
    case (crn)
      4'd0:    rd_val = CP15_ID;
      4'd1:    rd_val = o_ctrl;
      4'd2:    rd_val = o_ttbr;
      4'd3:    rd_val = o_dac;
      4'd5:    rd_val = fsr_q;
      4'd6:    rd_val = far_q;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= S_IDLE;
      word_q         <= '0;
      reg_q          <= '0;
      mode_q         <= '0;
      o_copro_done   <= 1'b0;
      o_copro_undef  <= 1'b0;
      o_reg_rd_en    <= 1'b0;
      o_reg_rd_index <= '0;
      o_reg_wr_en    <= 1'b0;
      o_reg_wr_index <= '0;
      o_reg_wr_data  <= '0;
      o_cache_inv    <= 1'b0;
      o_tlb_inv      <= 1'b0;
      o_ctrl         <= CTRL_RESET;
      o_ttbr         <= '0;
      o_dac          <= '0;
      fsr_q          <= '0;
      far_q          <= '0;
    end else begin
      o_copro_done  <= 1'b0;
      o_copro_undef <= 1'b0;
      o_reg_rd_en   <= 1'b0;
      o_reg_wr_en   <= 1'b0;
      o_cache_inv   <= 1'b0;
      o_tlb_inv     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_copro_dav) begin
            word_q <= i_copro_word;
            reg_q  <= i_copro_reg;
            mode_q <= i_copro_mode[4:0];
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!i_copro_dav) begin
            state <= S_IDLE;
          end else if (is_rejected(word_q, mode_q)) begin
            o_copro_done  <= 1'b1;
            o_copro_undef <= 1'b1;
            state         <= S_DONE;
          end else if (word_q[20]) begin
            o_reg_wr_en    <= 1'b1;
            o_reg_wr_index <= reg_q;
            o_reg_wr_data  <= rd_val;
            state          <= S_WRITE;
          end else begin
            o_reg_rd_en    <= 1'b1;
            o_reg_rd_index <= reg_q;
            state          <= S_READ;
          end
        end
        S_READ: begin
          state <= i_copro_dav ? S_READ_WAIT : S_IDLE;
        end
        S_READ_WAIT: begin
          // Past this point the MCR commits even if the issuer was flushed.
          case (crn)
            4'd1:    o_ctrl      <= i_reg_rd_data;
            4'd2:    o_ttbr      <= i_reg_rd_data;
            4'd3:    o_dac       <= i_reg_rd_data;
            4'd5:    fsr_q       <= i_reg_rd_data;
            4'd6:    far_q       <= i_reg_rd_data;
            4'd7:    o_cache_inv <= 1'b1;
            4'd8:    o_tlb_inv   <= 1'b1;
            default: ;
          endcase
          o_copro_done <= 1'b1;
          state        <= S_DONE;
        end
        S_WRITE: begin
          o_copro_done <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // MMU fault capture overrides a same-cycle MCR to c5/c6.
      if (i_fault_valid) begin
        fsr_q <= i_fsr;
        far_q <= i_far;
      end
    end
  end

  assign unused_ok = ^{word_q[31:28], word_q[23:21], word_q[15:12], word_q[7:5],
                       word_q[3:0], i_copro_mode[31:5]};

endmodule

// File: tb/tb_zap_cp15_responder.sv
// Directed bench for zap_cp15_responder with a register-file model and an
// event scoreboard keyed on strobe cycle.
module tb_zap_cp15_responder;

  localparam int PHY = 46;
  localparam int IW  = $clog2(PHY);
  localparam logic [31:0] ID   = 32'h4107_0000;
  localparam logic [31:0] FSR  = 32'h0000_0005;
  localparam logic [31:0] FAR  = 32'h0000_1234;
  localparam logic [4:0]  SVC  = 5'b10011;
  localparam logic [4:0]  USR  = 5'b10000;
  localparam int K_RD = 0, K_WR = 1, K_DONE = 2;

  logic clk = 1'b0;
  logic rst;
  logic dav;
  logic [31:0] word, mode;
  logic [IW-1:0] creg;
  logic done, undef, rd_en, wr_en, cinv, tinv;
  logic [IW-1:0] rd_idx, wr_idx;
  logic [31:0] rd_data, wr_data, ctrl, ttbr, dac;
  logic fault;
  logic [31:0] fsr, far_v;

  zap_cp15_responder dut (
    .i_clk(clk), .i_reset(rst), .i_copro_dav(dav), .i_copro_word(word),
    .i_copro_reg(creg), .i_copro_mode(mode), .o_copro_done(done),
    .o_copro_undef(undef), .o_reg_rd_en(rd_en), .o_reg_rd_index(rd_idx),
    .i_reg_rd_data(rd_data), .o_reg_wr_en(wr_en), .o_reg_wr_index(wr_idx),
    .o_reg_wr_data(wr_data), .i_fault_valid(fault), .i_fsr(fsr), .i_far(far_v),
    .o_ctrl(ctrl), .o_ttbr(ttbr), .o_dac(dac), .o_cache_inv(cinv), .o_tlb_inv(tinv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rf [PHY];
  always @(posedge clk) rd_data <= rd_en ? rf[rd_idx] : 32'hDEAD_BEEF;

  typedef struct {
    int          kind;
    int          cyc;
    int          idx;
    logic [31:0] data;
    logic        undef;
    logic        cinv;
    logic        tinv;
  } ev_t;
  ev_t sb[$];

  int checks = 0;
  int failures = 0;

  logic [31:0] m_c1, m_c2, m_c3, m_c5, m_c6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] crn);
    case (crn)
      4'd0:    return ID;
      4'd1:    return m_c1;
      4'd2:    return m_c2;
      4'd3:    return m_c3;
      4'd5:    return m_c5;
      4'd6:    return m_c6;
      default: return 32'h0;
    endcase
  endfunction

  task automatic push(input int kind, input int c, input int idx, input logic [31:0] d,
                      input logic u, input logic ci, input logic ti);
    ev_t e;
    e.kind = kind; e.cyc = c; e.idx = idx; e.data = d;
    e.undef = u; e.cinv = ci; e.tinv = ti;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    chk("event_expected", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_cycle", 32'(cyc), 32'(e.cyc));
      if (kind == K_RD) chk("rd_index", 32'(rd_idx), 32'(e.idx));
      if (kind == K_WR) begin
        chk("wr_index", 32'(wr_idx), 32'(e.idx));
        chk("wr_data", wr_data, e.data);
      end
      if (kind == K_DONE) begin
        chk("done_undef", 32'(undef), 32'(e.undef));
        chk("done_cache_inv", 32'(cinv), 32'(e.cinv));
        chk("done_tlb_inv", 32'(tinv), 32'(e.tinv));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rd_en) observe(K_RD);
    if (wr_en) observe(K_WR);
    if (done)  observe(K_DONE);
    if (!done && (cinv || tinv || undef))
      chk("pulse_without_done", {29'd0, cinv, tinv, undef}, 32'd0);
  end

  // One coprocessor request; drop_off >= 0 withdraws dav at that cycle offset.
  task automatic req(input logic l, input logic [3:0] crn, input logic [3:0] cp,
                     input logic [4:0] md, input int idx, input logic [31:0] val,
                     input logic bit4, input bit with_fault, input int drop_off);
    int t0;
    int n;
    bit rej;
    rej = (cp != 4'd15) || !bit4 || (md == USR);
    rf[idx] = val;
    @(negedge clk); #1;
    t0 = cyc;
    word = {4'hE, 4'hE, 3'b000, l, crn, 4'h0, cp, 3'b000, bit4, 4'h0};
    creg = IW'(idx);
    mode = {27'h0, md};
    dav  = 1'b1;
    if (drop_off == 1) begin
    end else if (rej) begin
      push(K_DONE, t0 + 2, 0, 0, 1'b1, 1'b0, 1'b0);
    end else if (l) begin
      push(K_WR, t0 + 2, idx, m_read(crn), 1'b0, 1'b0, 1'b0);
      push(K_DONE, t0 + 3, 0, 0, 1'b0, 1'b0, 1'b0);
    end else begin
      push(K_RD, t0 + 2, idx, 0, 1'b0, 1'b0, 1'b0);
      if (drop_off < 0) begin
        push(K_DONE, t0 + 4, 0, 0, 1'b0, crn == 4'd7, crn == 4'd8);
        case (crn)
          4'd1: m_c1 = val;
          4'd2: m_c2 = val;
          4'd3: m_c3 = val;
          4'd5: m_c5 = val;
          4'd6: m_c6 = val;
          default: ;
        endcase
        if (with_fault) begin
          m_c5 = FSR;
          m_c6 = FAR;
        end
      end
    end
    n = 0;
    forever begin
      @(negedge clk); #1;
      n++;
      fault = with_fault && (cyc == t0 + 3);
      if (drop_off >= 0 && cyc == t0 + drop_off) dav = 1'b0;
      if (sb.size() == 0) break;
      if (n > 16) begin
        chk("request_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        break;
      end
    end
    dav = 1'b0;
    fault = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < PHY; i++) rf[i] = 32'h0;
    rst = 1'b1; dav = 1'b0; word = '0; mode = '0; creg = '0;
    fault = 1'b0; fsr = FSR; far_v = FAR;
    m_c1 = 32'h78; m_c2 = 0; m_c3 = 0; m_c5 = 0; m_c6 = 0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 0);
    chk("rst_undef", 32'(undef), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_index", 32'(rd_idx), 0);
    chk("rst_wr_index", 32'(wr_idx), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ctrl", ctrl, 32'h78);
    chk("rst_ttbr", ttbr, 0);
    chk("rst_dac", dac, 0);
    chk("rst_inv", {30'd0, cinv, tinv}, 0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    req(1'b1, 4'd0, 4'd15, SVC, 3, 0, 1'b1, 1'b0, -1);
    req(1'b0, 4'd2, 4'd15, SVC, 5, 32'h0000_4000, 1'b1, 1'b0, -1);
    chk("ttbr_after_mcr", ttbr, 32'h0000_4000);
    req(1'b0, 4'd7, 4'd15, SVC, 6, 32'h1111_2222, 1'b1, 1'b0, -1);
    chk("c7_ctrl", ctrl, m_c1);
    chk("c7_ttbr", ttbr, m_c2);
    chk("c7_dac", dac, m_c3);
    req(1'b0, 4'd8, 4'd15, SVC, 6, 32'h3333_4444, 1'b1, 1'b0, -1);
    req(1'b1, 4'd1, 4'd15, USR, 4, 0, 1'b1, 1'b0, -1);
    req(1'b0, 4'd1, 4'd14, SVC, 4, 32'hBAD0_0001, 1'b1, 1'b0, -1);
    req(1'b0, 4'd3, 4'd15, SVC, 4, 32'hBAD0_0002, 1'b0, 1'b0, -1);
    chk("reject_ctrl", ctrl, 32'h78);
    chk("reject_dac", dac, 0);
    req(1'b0, 4'd3, 4'd15, SVC, 8, 32'h5555_0001, 1'b1, 1'b0, -1);
    chk("dac_after_mcr", dac, 32'h5555_0001);
    req(1'b1, 4'd3, 4'd15, SVC, 12, 0, 1'b1, 1'b0, -1);
    req(1'b1, 4'd4, 4'd15, SVC, 13, 0, 1'b1, 1'b0, -1);

    req(1'b0, 4'd5, 4'd15, SVC, 7, 32'h0000_AAAA, 1'b1, 1'b1, -1);
    req(1'b1, 4'd5, 4'd15, SVC, 14, 0, 1'b1, 1'b0, -1);
    req(1'b1, 4'd6, 4'd15, SVC, 15, 0, 1'b1, 1'b0, -1);

    req(1'b0, 4'd1, 4'd15, SVC, 9, 32'h0000_1005, 1'b1, 1'b0, -1);
    chk("ctrl_after_mcr", ctrl, 32'h0000_1005);
    req(1'b0, 4'd1, 4'd15, SVC, 10, 32'h0000_FFFF, 1'b1, 1'b0, 2);
    chk("abort_read_ctrl", ctrl, 32'h0000_1005);
    req(1'b0, 4'd1, 4'd15, SVC, 10, 32'h0000_EEEE, 1'b1, 1'b0, 1);
    chk("abort_decode_ctrl", ctrl, 32'h0000_1005);
    req(1'b1, 4'd1, 4'd15, SVC, 11, 0, 1'b1, 1'b0, -1);

    // Asynchronous reset while the write strobe is up.
    @(negedge clk); #1;
    t0 = cyc;
    word = {4'hE, 4'hE, 3'b000, 1'b1, 4'd1, 4'h0, 4'd15, 3'b000, 1'b1, 4'h0};
    creg = IW'(2);
    mode = {27'h0, SVC};
    dav = 1'b1;
    push(K_WR, t0 + 2, 2, m_read(4'd1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8 && cyc < t0 + 2; i++) begin
      @(negedge clk); #1;
    end
    chk("pre_reset_wr_en", 32'(wr_en), 1);
    rst = 1'b1;
    #1;
    chk("mid_write_reset_wr_en", 32'(wr_en), 0);
    chk("mid_write_reset_ctrl", ctrl, 32'h78);
    chk("mid_write_reset_done", 32'(done), 0);
    m_c1 = 32'h78; m_c2 = 0; m_c3 = 0; m_c5 = 0; m_c6 = 0;
    dav = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    req(1'b1, 4'd1, 4'd15, SVC, 2, 0, 1'b1, 1'b0, -1);
    req(1'b1, 4'd5, 4'd15, SVC, 2, 0, 1'b1, 1'b0, -1);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "global timeout");
  end

endmodule
